rom_loader: RTL and testbench

- Boot-time writer for the instruction ROM that the CPU reads. Receives a byte stream (host or UART front end) and assembles big-endian 32-bit instruction words.
- Writes each word into the ROM write port at consecutive word addresses and holds the CPU in reset until a complete, checksum-valid image is loaded.
- Sits in sopc between the byte source and the ROM write port. Replaces $readmemh preloading on hardware.

---
 rtl/rom_loader_pkg.sv | 18 +
 rtl/rom_loader_word_assembler.sv | 36 +++
 rtl/rom_loader.sv | 137 +++++++++++++
 tb/tb_rom_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot ROM loader: FSM state encoding and
// stream-format constants (16-bit word count, 4 bytes per instruction word).
// No ports; imported by rom_loader and word_assembler.
package loader_defines;

  localparam int COUNT_WIDTH    = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_COUNT_HI = 3'd0,
    S_COUNT_LO = 3'd1,
    S_DATA     = 3'd2,
    S_CHECK    = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_e;

endpackage

// File: rtl/rom_loader_word_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit words; flags the 4th byte.
// Ports: clock/reset (sync, active-high), clear_i drops any partial word,
//        byte_en_i/byte_i accepted data byte, word_o/word_done_o completed word (same cycle).
module word_assembler
  import loader_defines::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [23:0]      shift_q;
  logic [CNT_W-1:0] cnt_q;

  // Word is presented combinationally with its last byte so the caller can
  // register it together with the write strobe on the same edge.
  assign word_o      = {shift_q, byte_i};
  assign word_done_o = byte_en_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot-time ROM writer: parses COUNT_HI, COUNT_LO, N words, CHECK from a byte
// stream, writes words to consecutive ROM addresses, releases cpu_reset on a
// valid image. Ports: byte stream in (valid/ready), restart pulse, ROM write
// port out, cpu_reset/done/error status out. All outputs registered.
module rom_loader
  import loader_defines::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  restart,
  output logic                  rom_write_enable,
  output logic [ADDR_WIDTH-1:0] rom_write_address,
  output logic [31:0]           rom_write_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  state_e                 state_q;
  logic                   ready_q;
  logic                   we_q;
  logic                   cpu_reset_q;
  logic                   done_q;
  logic                   error_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [7:0]             chk_q;
  logic [7:0]             chk_d;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [31:0]            data_q;

  logic        xfer;
  logic        data_en;
  logic        word_done;
  logic        last_word;
  logic [31:0] word;

  // A byte offered alongside restart is dropped, not consumed.
  assign xfer    = byte_valid && ready_q && !restart;
  assign data_en = xfer && (state_q == S_DATA);
  assign count_d = {count_q[7:0], byte_data};
  assign chk_d   = chk_q ^ byte_data;

  assign last_word = ({{(32-ADDR_WIDTH){1'b0}}, idx_q} ==
                      ({{(32-COUNT_WIDTH){1'b0}}, count_q} - 32'd1));

  word_assembler u_asm (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (restart),
    .byte_en_i   (data_en),
    .byte_i      (byte_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      state_q     <= S_COUNT_HI;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      // restart keeps the last ROM write address/data visible
      if (reset) begin
        addr_q <= '0;
        data_q <= '0;
      end
    end else begin
      we_q <= 1'b0;
      if (xfer) begin
        chk_q <= chk_d;
        case (state_q)
          S_COUNT_HI: begin
            count_q <= {8'h00, byte_data};
            state_q <= S_COUNT_LO;
          end
          S_COUNT_LO: begin
            count_q <= count_d;
            if (count_d == '0) begin
              state_q <= S_CHECK;
            end else if ({16'd0, count_d} > MAX_WORDS) begin
              // Oversize is rejected here, so idx_q can never wrap.
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (word_done) begin
              we_q   <= 1'b1;
              addr_q <= idx_q;
              data_q <= word;
              idx_q  <= idx_q + ADDR_WIDTH'(1);
              if (last_word) state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            ready_q <= 1'b0;
            if (byte_data == chk_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready        = ready_q;
  assign rom_write_enable  = we_q;
  assign rom_write_address = addr_q;
  assign rom_write_data    = data_q;
  assign cpu_reset         = cpu_reset_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: two instances (ADDR_WIDTH 10 and 2) share one byte
// stream; a stream-parsing reference model predicts writes and final status.
// Directed scenarios followed by randomized loads with restart/reset between.
module tb_rom_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, restart, byte_valid;
  logic [7:0]  byte_data;

  logic        rdy1, we1, cr1, dn1, er1;
  logic [9:0]  a1;
  logic [31:0] d1;
  logic        rdy2, we2, cr2, dn2, er2;
  logic [1:0]  a2;
  logic [31:0] d2;

  rom_loader #(.ADDR_WIDTH(10)) dut1 (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(rdy1), .restart(restart), .rom_write_enable(we1),
    .rom_write_address(a1), .rom_write_data(d1), .cpu_reset(cr1),
    .done(dn1), .error(er1)
  );

  rom_loader #(.ADDR_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(rdy2), .restart(restart), .rom_write_enable(we2),
    .rom_write_address(a2), .rom_write_data(d2), .cpu_reset(cr2),
    .done(dn2), .error(er2)
  );

  logic [7:0]  stim[$];
  logic [47:0] exp_q[$], exp1[$], exp2[$], got1[$], got2[$];
  logic [47:0] held1, held2;
  int checks = 0;
  int errors = 0;
  int oc1, dc1, oc2, dc2;

  // Each write strobe is one cycle wide, so it is seen at exactly one negedge.
  always @(negedge clock) begin
    if (we1 === 1'b1) got1.push_back({6'd0, a1, d1});
    if (we2 === 1'b1) got2.push_back({14'd0, a2, d2});
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: parse the stream as a whole. oc: 0 pending, 1 done, 2 error;
  // dc: index of the byte whose transfer decides the outcome.
  task automatic build_expect(input int maxw, output int oc, output int dc);
    int n, base;
    logic [7:0] x;
    exp_q.delete();
    oc = 0;
    dc = 1 << 30;
    if (stim.size() < 2) return;
    n = (int'(stim[0]) << 8) | int'(stim[1]);
    if (n > maxw) begin
      oc = 2;
      dc = 1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      base = 2 + 4 * w;
      if (stim.size() >= base + 4)
        exp_q.push_back({16'(w), stim[base], stim[base+1], stim[base+2], stim[base+3]});
    end
    base = 2 + 4 * n;
    if (stim.size() > base) begin
      x = 8'h00;
      for (int j = 0; j < base; j++) x ^= stim[j];
      oc = (stim[base] == x) ? 1 : 2;
      dc = base;
    end
  endtask

  task automatic check_status(input string tag, input int s1, input int s2);
    check({tag, " dut1 rdy/cpurst/done/err"}, {44'd0, rdy1, cr1, dn1, er1},
          {44'd0, s1 == 0, s1 != 1, s1 == 1, s1 == 2});
    check({tag, " dut2 rdy/cpurst/done/err"}, {44'd0, rdy2, cr2, dn2, er2},
          {44'd0, s2 == 0, s2 != 1, s2 == 1, s2 == 2});
  endtask

  task automatic check_idle(input string tag);
    check_status(tag, 0, 0);
    check({tag, " we"}, {46'd0, we1, we2}, 48'd0);
    check({tag, " dut1 addr/data"}, {6'd0, a1, d1}, held1);
    check({tag, " dut2 addr/data"}, {14'd0, a2, d2}, held2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'($urandom);
    @(posedge clock); #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    held1 = '0;
    held2 = '0;
    check_idle("after reset");
  endtask

  task automatic do_restart();
    restart = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'($urandom);
    @(posedge clock); #1;
    restart = 1'b0;
    byte_valid = 1'b0;
    check_idle("after restart");
  endtask

  task automatic run_load(input string tag, input bit bub);
    int nb;
    build_expect(1024, oc1, dc1);
    exp1 = exp_q;
    build_expect(4, oc2, dc2);
    exp2 = exp_q;
    got1.delete();
    got2.delete();
    for (int i = 0; i < stim.size(); i++) begin
      nb = bub ? $urandom_range(0, 3) : 0;
      repeat (nb) begin @(posedge clock); #1; end
      byte_valid = 1'b1;
      byte_data = stim[i];
      @(posedge clock); #1;
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      check_status($sformatf("%s byte%0d", tag, i), (i >= dc1) ? oc1 : 0, (i >= dc2) ? oc2 : 0);
    end
    repeat (2) begin @(posedge clock); #1; end
    check({tag, " dut1 nwrites"}, 48'(got1.size()), 48'(exp1.size()));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      check($sformatf("%s dut1 write%0d", tag, i), got1[i], exp1[i]);
    check({tag, " dut2 nwrites"}, 48'(got2.size()), 48'(exp2.size()));
    for (int i = 0; i < exp2.size() && i < got2.size(); i++)
      check($sformatf("%s dut2 write%0d", tag, i), got2[i], exp2[i]);
    if (exp1.size() > 0) held1 = exp1[exp1.size()-1];
    if (exp2.size() > 0) held2 = exp2[exp2.size()-1];
  endtask

  task automatic load_scen1(input logic [7:0] chk);
    stim = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    stim.push_back(chk);
  endtask

  initial begin
    reset = 1'b1;
    restart = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    held1 = '0;
    held2 = '0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Two-word image with a good checksum.
    load_scen1(8'h30);
    run_load("s1", 1'b0);
    check("s1 word0 const", (got1.size() > 0) ? got1[0] : '1, {16'h0000, 32'h34011100});
    check("s1 word1 const", (got1.size() > 1) ? got1[1] : '1, {16'h0001, 32'h34020020});
    check("s1 done const", {45'd0, dn1, cr1, rdy1}, {45'd0, 3'b100});

    // Bad checksum: words still land, load fails.
    do_restart();
    load_scen1(8'h31);
    run_load("badchk", 1'b0);
    check("badchk err const", {45'd0, er1, dn1, cr1}, {45'd0, 3'b101});

    // Empty image.
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    run_load("empty", 1'b0);

    // Count 5: oversize for the 4-word instance, legal for the other.
    do_reset();
    stim = '{8'h00, 8'h05};
    run_load("oversize", 1'b0);
    check("oversize dut2 const", {45'd0, er2, rdy2, cr2}, {45'd0, 3'b101});

    // Bubbles between bytes.
    do_reset();
    load_scen1(8'h30);
    run_load("bubbles", 1'b1);

    // Reset after 6 bytes, then the full image.
    do_reset();
    load_scen1(8'h30);
    while (stim.size() > 6) void'(stim.pop_back());
    run_load("part6", 1'b0);
    do_reset();
    load_scen1(8'h30);
    run_load("full", 1'b0);

    // Restart from done, then a partial word abandoned by restart.
    do_restart();
    load_scen1(8'h30);
    while (stim.size() > 8) void'(stim.pop_back());
    run_load("part8", 1'b0);
    do_restart();
    load_scen1(8'h30);
    run_load("after part8", 1'b0);

    // Randomized images, including the 4/5 word boundary of the small instance.
    for (int it = 0; it < 12; it++) begin
      int n;
      int keep;
      logic [7:0] x;
      do_restart();
      if (it % 3 == 2) do_reset();
      n = (it < 2) ? 4 + it : $urandom_range(0, 6);
      stim.delete();
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      repeat (4 * n) stim.push_back(8'($urandom));
      x = 8'h00;
      foreach (stim[j]) x ^= stim[j];
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      stim.push_back(x);
      if ($urandom_range(0, 4) == 0) begin
        keep = $urandom_range(1, stim.size());
        while (stim.size() > keep) void'(stim.pop_back());
      end
      run_load($sformatf("rand%0d", it), it[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
